// File: rtl/mode_switch_ctrl_if.sv
// Bus between the control unit (master) and the kernel/program mode sequencer (slave).
interface mode_switch_ctrl_if #(
  parameter int PC_WIDTH      = 32,
  parameter int QUANTUM_WIDTH = 16
);
  logic                     syscall_req;
  logic                     kernel_ret;
  logic                     irq;
  logic                     quantum_load;
  logic [QUANTUM_WIDTH-1:0] quantum_value;
  logic [PC_WIDTH-1:0]      pc_current;
  logic [PC_WIDTH-1:0]      resume_pc;
  logic                     prog_or_kernel;
  logic                     pc_load;
  logic [PC_WIDTH-1:0]      pc_target;
  logic [PC_WIDTH-1:0]      saved_pc;
  logic [1:0]               cause;
  logic                     stall;

  modport master (
    output syscall_req, kernel_ret, irq, quantum_load, quantum_value, pc_current, resume_pc,
    input  prog_or_kernel, pc_load, pc_target, saved_pc, cause, stall
  );

  modport slave (
    input  syscall_req, kernel_ret, irq, quantum_load, quantum_value, pc_current, resume_pc,
    output prog_or_kernel, pc_load, pc_target, saved_pc, cause, stall
  );
endinterface

// File: rtl/mode_switch_ctrl.sv
// Kernel/program mode sequencer: arbitrates syscall, irq and time-slice expiry into kernel entry.
// Define MODE_SWITCH_TIMESLICE_EN to build the quantum register, slice counter and timer event.
module mode_switch_ctrl #(
  parameter int                  PC_WIDTH      = 32,
  parameter int                  QUANTUM_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] KERNEL_VECTOR = '0
) (
  input logic              clock,
  input logic              reset,
  mode_switch_ctrl_if.slave bus
);

  // state   | meaning
  // KERNEL  | kernel mode, waits for kernel_ret (reset state)
  // ENTER_P | one-cycle redirect to the program resume PC
  // PROG    | program mode, watches syscall > irq > timer
  // ENTER_K | one-cycle redirect to the kernel vector
  typedef enum logic [1:0] {KERNEL, ENTER_P, PROG, ENTER_K} state_t;

  state_t state;
  logic   timer_hit;
  logic   prog_event;

`ifdef MODE_SWITCH_TIMESLICE_EN
  logic [QUANTUM_WIDTH-1:0] quantum;
  logic [QUANTUM_WIDTH-1:0] count;

  assign timer_hit = (count == QUANTUM_WIDTH'(1)) && (quantum != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quantum <= '0;
    end else if (bus.quantum_load) begin
      quantum <= bus.quantum_value;
    end
  end

  // Slice counter is armed on return; quantum writes during PROG only affect the next slice.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state == KERNEL && bus.kernel_ret) begin
      count <= bus.quantum_load ? bus.quantum_value : quantum;
    end else if (state == PROG && !prog_event && count != '0) begin
      count <= count - QUANTUM_WIDTH'(1);
    end
  end
`else
  logic unused_quantum;
  assign unused_quantum = ^{bus.quantum_load, bus.quantum_value};
  assign timer_hit      = 1'b0;
`endif

  assign prog_event         = bus.syscall_req || bus.irq || timer_hit;
  assign bus.prog_or_kernel = (state == PROG);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= KERNEL;
      bus.pc_load   <= 1'b0;
      bus.stall     <= 1'b0;
      bus.pc_target <= KERNEL_VECTOR;
      bus.saved_pc  <= '0;
      bus.cause     <= 2'b00;
    end else begin
      bus.pc_load <= 1'b0;
      bus.stall   <= 1'b0;
      case (state)
        KERNEL: begin
          if (bus.kernel_ret) begin
            state         <= ENTER_P;
            bus.pc_target <= bus.resume_pc;
            bus.pc_load   <= 1'b1;
            bus.stall     <= 1'b1;
          end
        end
        ENTER_P: state <= PROG;
        PROG: begin
          if (prog_event) begin
            state         <= ENTER_K;
            bus.pc_target <= KERNEL_VECTOR;
            bus.pc_load   <= 1'b1;
            bus.stall     <= 1'b1;
            if (bus.syscall_req) begin
              bus.saved_pc <= bus.pc_current + PC_WIDTH'(1);
              bus.cause    <= 2'b01;
            end else if (bus.irq) begin
              // Interrupted instruction is squashed and re-executed on return.
              bus.saved_pc <= bus.pc_current;
              bus.cause    <= 2'b10;
            end else begin
              bus.saved_pc <= bus.pc_current;
              bus.cause    <= 2'b11;
            end
          end
        end
        ENTER_K: state <= KERNEL;
        default: state <= KERNEL;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Directed plus randomized bench for mode_switch_ctrl; follows MODE_SWITCH_TIMESLICE_EN like the DUT.
module tb_mode_switch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mode_switch_ctrl_if #(.PC_WIDTH(32), .QUANTUM_WIDTH(16)) bus ();

  mode_switch_ctrl #(.PC_WIDTH(32), .QUANTUM_WIDTH(16), .KERNEL_VECTOR(32'h0)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: program/transition flags, slice length and cycles already run in PROG.
  bit          m_prog, m_transit, m_to_prog;
  logic [31:0] m_target, m_saved;
  logic [1:0]  m_cause;
  int          m_q, m_slice, m_exec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pok"}, 64'(bus.prog_or_kernel), 64'd0);
    chk({tag, "_pcl"}, 64'(bus.pc_load), 64'd0);
    chk({tag, "_stl"}, 64'(bus.stall), 64'd0);
    chk({tag, "_tgt"}, 64'(bus.pc_target), 64'd0);
    chk({tag, "_spc"}, 64'(bus.saved_pc), 64'd0);
    chk({tag, "_cau"}, 64'(bus.cause), 64'd0);
  endtask

  task automatic model_reset();
    m_prog = 0; m_transit = 0; m_to_prog = 0;
    m_target = 32'h0; m_saved = 32'h0; m_cause = 2'b00;
    m_q = 0; m_slice = 0; m_exec = 0;
  endtask

  // Applies one clock edge worth of rules to the model using the current inputs.
  task automatic model_edge();
    bit timer;
    timer = 0;
`ifdef MODE_SWITCH_TIMESLICE_EN
    timer = (m_q != 0) && (m_slice != 0) && (m_exec + 1 == m_slice);
`endif
    if (m_transit) begin
      m_transit = 0;
      m_prog    = m_to_prog;
      m_exec    = 0;
    end else if (!m_prog) begin
      if (bus.kernel_ret) begin
        m_transit = 1; m_to_prog = 1;
        m_target  = bus.resume_pc;
        m_slice   = bus.quantum_load ? int'(bus.quantum_value) : m_q;
      end
    end else if (bus.syscall_req || bus.irq || timer) begin
      m_transit = 1; m_to_prog = 0;
      m_target  = 32'h0;
      if (bus.syscall_req) begin m_saved = bus.pc_current + 32'd1; m_cause = 2'b01; end
      else if (bus.irq)    begin m_saved = bus.pc_current;         m_cause = 2'b10; end
      else                 begin m_saved = bus.pc_current;         m_cause = 2'b11; end
    end else begin
      m_exec++;
    end
`ifdef MODE_SWITCH_TIMESLICE_EN
    if (bus.quantum_load) m_q = int'(bus.quantum_value);
`endif
  endtask

  initial begin
    int cnt;
    bus.syscall_req = 0; bus.kernel_ret = 0; bus.irq = 0; bus.quantum_load = 0;
    bus.quantum_value = '0; bus.pc_current = '0; bus.resume_pc = '0;

    // Reset values
    tick(); tick();
    chk_reset_vals("rst");
    rst = 0;

    // Return to program at 0x100
    bus.resume_pc = 32'h100; bus.kernel_ret = 1;
    tick();
    bus.kernel_ret = 0;
    chk("ret_pcl", 64'(bus.pc_load), 64'd1);
    chk("ret_stl", 64'(bus.stall), 64'd1);
    chk("ret_tgt", 64'(bus.pc_target), 64'h100);
    chk("ret_pok", 64'(bus.prog_or_kernel), 64'd0);
    tick();
    chk("prog_pok", 64'(bus.prog_or_kernel), 64'd1);
    chk("prog_pcl", 64'(bus.pc_load), 64'd0);

    // Syscall at 0x104
    bus.pc_current = 32'h104; bus.syscall_req = 1;
    tick();
    bus.syscall_req = 0;
    chk("sys_pcl", 64'(bus.pc_load), 64'd1);
    chk("sys_tgt", 64'(bus.pc_target), 64'h0);
    chk("sys_spc", 64'(bus.saved_pc), 64'h105);
    chk("sys_cau", 64'(bus.cause), 64'd1);
    chk("sys_pok", 64'(bus.prog_or_kernel), 64'd0);
    tick();
    chk("kern_stl", 64'(bus.stall), 64'd0);
    chk("kern_pok", 64'(bus.prog_or_kernel), 64'd0);

    // Minimum round trip, then syscall and irq together
    bus.resume_pc = 32'h1F0; bus.kernel_ret = 1;
    tick();
    bus.kernel_ret = 0;
    tick();
    chk("rt_pok", 64'(bus.prog_or_kernel), 64'd1);
    bus.pc_current = 32'h200; bus.syscall_req = 1; bus.irq = 1;
    tick();
    bus.syscall_req = 0;
    chk("both_cau", 64'(bus.cause), 64'd1);
    chk("both_spc", 64'(bus.saved_pc), 64'h201);
    tick();
    tick();
    chk("irqmask_pok", 64'(bus.prog_or_kernel), 64'd0);
    chk("irqmask_pcl", 64'(bus.pc_load), 64'd0);
    bus.kernel_ret = 1; bus.resume_pc = 32'h201;
    tick();
    bus.kernel_ret = 0;
    chk("hold_cau", 64'(bus.cause), 64'd1);
    tick();
    bus.pc_current = 32'h300;
    tick();
    chk("irq_cau", 64'(bus.cause), 64'd2);
    chk("irq_spc", 64'(bus.saved_pc), 64'h300);
    chk("irq_pcl", 64'(bus.pc_load), 64'd1);
    bus.irq = 0;
    tick();

`ifdef MODE_SWITCH_TIMESLICE_EN
    // Quantum 3 loaded with return: exactly three PROG cycles
    bus.quantum_load = 1; bus.quantum_value = 16'd3; bus.kernel_ret = 1;
    tick();
    bus.quantum_load = 0; bus.kernel_ret = 0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      bus.pc_current = 32'h400 + 32'(i);
      chk($sformatf("tmr_pok%0d", i), 64'(bus.prog_or_kernel), 64'd1);
      tick();
    end
    chk("tmr_cau", 64'(bus.cause), 64'd3);
    chk("tmr_spc", 64'(bus.saved_pc), 64'h403);
    chk("tmr_pcl", 64'(bus.pc_load), 64'd1);
    tick();
`else
    // Quantum loads are ignored: no timer entry
    bus.quantum_load = 1; bus.quantum_value = 16'd2; bus.kernel_ret = 1;
    tick();
    bus.quantum_load = 0; bus.kernel_ret = 0;
    tick();
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.pc_load || !bus.prog_or_kernel || bus.cause == 2'b11) cnt++;
      tick();
    end
    chk("notmr_evts", 64'(cnt), 64'd0);
    bus.syscall_req = 1;
    tick();
    bus.syscall_req = 0;
    tick();
`endif

    // Quantum 0: no preemption over 1000 cycles
    bus.quantum_load = 1; bus.quantum_value = 16'd0; bus.kernel_ret = 1;
    tick();
    bus.quantum_load = 0; bus.kernel_ret = 0;
    tick();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.pc_current = 32'h600 + 32'(i);
      if (bus.pc_load || !bus.prog_or_kernel) cnt++;
      tick();
    end
    chk("q0_evts", 64'(cnt), 64'd0);

    // Reset asserted in ENTER_K
    bus.pc_current = 32'h777; bus.syscall_req = 1;
    tick();
    bus.syscall_req = 0;
    chk("ek_pcl", 64'(bus.pc_load), 64'd1);
    rst = 1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst = 0;
    bus.resume_pc = 32'h500; bus.kernel_ret = 1;
    tick();
    bus.kernel_ret = 0;
    chk("post_pcl", 64'(bus.pc_load), 64'd1);
    chk("post_tgt", 64'(bus.pc_target), 64'h500);
    tick();
    chk("post_pok", 64'(bus.prog_or_kernel), 64'd1);

    // Randomized run against the model
    rst = 1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 0;
    bus.irq = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.syscall_req   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) bus.irq = ~bus.irq;
      bus.kernel_ret    = ($urandom_range(0, 2) == 0);
      bus.quantum_load  = ($urandom_range(0, 5) == 0);
      bus.quantum_value = 16'($urandom_range(0, 6));
      bus.pc_current    = $urandom;
      bus.resume_pc     = $urandom;
      model_edge();
      tick();
      chk("rnd_pok", 64'(bus.prog_or_kernel), 64'(m_prog && !m_transit));
      chk("rnd_pcl", 64'(bus.pc_load), 64'(m_transit));
      chk("rnd_stl", 64'(bus.stall), 64'(m_transit));
      chk("rnd_tgt", 64'(bus.pc_target), 64'(m_target));
      chk("rnd_spc", 64'(bus.saved_pc), 64'(m_saved));
      chk("rnd_cau", 64'(bus.cause), 64'(m_cause));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mode_switch_ctrl.md
# mode_switch_ctrl

Sequences transitions between kernel mode and user-program mode for the processor's control unit. Arbitrates the three events that force kernel entry: system call, external interrupt, and time-slice expiry. On each kernel entry it captures the return PC and the cause, and redirects the PC to the kernel vector. On kernel return it resumes the program. It drives the processor's `prog_or_kernel` mode line and sits between the control unit and the PC register.

## Interface
- `PC_WIDTH`, 32: width of all PC values.
- `QUANTUM_WIDTH`, 16: width of the time-slice counter.
- `KERNEL_VECTOR`, 0: PC loaded on every kernel entry.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `syscall_req`  in  1  one-cycle pulse from the control unit; honoured only in PROG.
- `kernel_ret`  in  1  one-cycle pulse from the control unit; honoured only in KERNEL.
- `irq`  in  1  external interrupt, level-sensitive; honoured only in PROG.
- `quantum_load`  in  1  writes `quantum_value` into the quantum register.
- `quantum_value`  in  QUANTUM_WIDTH  time slice in PROG cycles; 0 disables preemption.
- `pc_current`  in  PC_WIDTH  PC of the instruction currently in execute.
- `resume_pc`  in  PC_WIDTH  program PC supplied by the kernel for return.
- `prog_or_kernel`  out  1  1 = program mode, 0 = kernel mode.
- `pc_load`  out  1  one-cycle pulse; the PC register loads `pc_target`.
- `pc_target`  out  PC_WIDTH  redirect address.
- `saved_pc`  out  PC_WIDTH  return PC captured at the last kernel entry.
- `cause`  out  2  reason for the last entry: 00 none, 01 syscall, 10 irq, 11 timer.
- `stall`  out  1  freezes the pipeline during transition states.

## Operation
- States:
  - KERNEL: reset state.
  - ENTER_P: transition into program mode.
  - PROG: program mode.
  - ENTER_K: transition into kernel mode.
- All outputs are registered, except `prog_or_kernel`, which is decoded as `state == PROG`.
- KERNEL, on `kernel_ret`:
  - go to ENTER_P.
  - latch `pc_target <= resume_pc`.
  - load the counter from the quantum register. If `quantum_load` is asserted in the same cycle, load from `quantum_value` instead.
- ENTER_P (1 cycle): `pc_load = 1`, `stall = 1`, then go to PROG.
- PROG, events in fixed priority syscall > irq > timer:
  - syscall: `saved_pc <= pc_current + 1`, `cause <= 01`.
  - irq: `saved_pc <= pc_current`, `cause <= 10`. The instruction is squashed and re-executed on return.
  - timer: taken when the counter equals 1 and the quantum is nonzero. `saved_pc <= pc_current`, `cause <= 11`.
  - Any event: `pc_target <= KERNEL_VECTOR`, go to ENTER_K.
- Counter: decrements on each PROG cycle with no event. It never wraps; it holds at 0 when the quantum is 0.
- ENTER_K (1 cycle): `pc_load = 1`, `stall = 1`, then go to KERNEL.
- Quantum register: written by `quantum_load` in any state. A write during PROG does not alter the running counter.
- Masking:
  - `syscall_req` and `irq` are ignored in KERNEL, ENTER_P and ENTER_K.
  - `kernel_ret` is ignored outside KERNEL.
  - A held `irq` is taken in the first PROG cycle after re-entry.
- Reset, asynchronous, including mid-transition:
  - state KERNEL; `prog_or_kernel` 0.
  - `pc_load` 0, `stall` 0.
  - `pc_target` = KERNEL_VECTOR.
  - `saved_pc` 0, `cause` 00.
  - counter 0, quantum register 0.

## Timing
- Entry latency: an event sampled at edge N gives ENTER_K in cycle N+1 with `pc_load` and `stall` high and `prog_or_kernel` low. KERNEL follows in cycle N+2.
- Return latency: `kernel_ret` at edge N gives ENTER_P in cycle N+1 (`pc_load`, `stall`). `prog_or_kernel` = 1 from cycle N+2.
- With quantum Q ≥ 1, the program executes exactly Q PROG cycles. The timer event is sampled on the Q-th cycle.
- `saved_pc` and `cause` update at the same edge the state leaves PROG. Both are stable throughout KERNEL.
- Minimum round trip, PROG → KERNEL → PROG: 4 cycles when `kernel_ret` is asserted in the first KERNEL cycle.

## Configuration
- `MODE_SWITCH_TIMESLICE_EN` defined:
  - the counter, quantum register and timer event are built.
- Not defined:
  - the counter and quantum register are removed.
  - `quantum_load` and `quantum_value` are ignored.
  - cause 11 is never produced.
  - program mode ends only on syscall or irq.

## Test plan
- Reset then `kernel_ret` with `resume_pc` = 0x100 -> `pc_load` with `pc_target` 0x100 in the next cycle; `prog_or_kernel` = 1 one cycle later.
- In PROG with `pc_current` = 0x104, pulse `syscall_req` -> ENTER_K with `pc_target` 0, `saved_pc` 0x105, `cause` 01; `prog_or_kernel` 0.
- `syscall_req` and `irq` together at `pc_current` = 0x200 -> `cause` 01, `saved_pc` 0x201. After `kernel_ret`, `irq` still high -> `cause` 10 on the first PROG cycle.
- `quantum_value` = 3 loaded with `kernel_ret` -> exactly 3 PROG cycles, then `cause` 11 with `saved_pc` = `pc_current` of the third cycle. Quantum 0 -> no preemption over 1000 cycles.
- Assert `reset` during ENTER_K -> all outputs return to reset values immediately (asynchronously); `kernel_ret` then works normally.
- With `MODE_SWITCH_TIMESLICE_EN` undefined: quantum 2 loaded -> no timer entry and `cause` never 11.
